// File: rtl/mdu_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// The result is computed at the start edge and parked in pending registers;
// busy models the iterative latency and the commit lands when it falls.
module mdu_unit #(
  parameter int unsigned WIDTH       = 32,
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       MDUOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO
);

  localparam int unsigned MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES - 1);

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_d;
  logic [WIDTH-1:0] hi_d, lo_d;
  logic [WIDTH-1:0] phi_q, phi_d, plo_q, plo_d;

  logic [2*WIDTH-1:0] a_sx, b_sx, prod_s, prod_u;
  logic             a_neg, b_neg, b_zero;
  logic [WIDTH-1:0] a_mag, b_mag, b_div_s, b_div_u;
  logic [WIDTH-1:0] qs_mag, rs_mag, qs, rs, qu, ru;
  logic [WIDTH-1:0] res_hi, res_lo;

  // Products: lower 2*WIDTH bits of sign/zero-extended operands are exact.
  always_comb begin
    a_sx   = {{WIDTH{A[WIDTH-1]}}, A};
    b_sx   = {{WIDTH{B[WIDTH-1]}}, B};
    prod_s = a_sx * b_sx;
    prod_u = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
  end

  // Division via magnitudes; the most-negative / -1 case falls out as LO=A, HI=0.
  // A zero divisor is swapped for 1 to keep the divider X-free; its result is overridden below.
  always_comb begin
    a_neg   = A[WIDTH-1];
    b_neg   = B[WIDTH-1];
    b_zero  = (B == '0);
    a_mag   = a_neg ? (WIDTH'(0) - A) : A;
    b_mag   = b_neg ? (WIDTH'(0) - B) : B;
    b_div_s = b_zero ? WIDTH'(1) : b_mag;
    b_div_u = b_zero ? WIDTH'(1) : B;
    qs_mag  = a_mag / b_div_s;
    rs_mag  = a_mag % b_div_s;
    qs      = (a_neg ^ b_neg) ? (WIDTH'(0) - qs_mag) : qs_mag;
    rs      = a_neg ? (WIDTH'(0) - rs_mag) : rs_mag;
    qu      = A / b_div_u;
    ru      = A % b_div_u;
  end

  // Result select for the pending registers.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    case (MDUOp)
      OP_MULT:  begin res_hi = prod_s[2*WIDTH-1:WIDTH]; res_lo = prod_s[WIDTH-1:0]; end
      OP_MULTU: begin res_hi = prod_u[2*WIDTH-1:WIDTH]; res_lo = prod_u[WIDTH-1:0]; end
      OP_DIV:   begin res_hi = b_zero ? A : rs; res_lo = b_zero ? '1 : qs; end
      OP_DIVU:  begin res_hi = b_zero ? A : ru; res_lo = b_zero ? '1 : qu; end
      default:  begin res_hi = '0; res_lo = '0; end
    endcase
  end

  // Next-state and register updates; requests outside IDLE are dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy;
    hi_d    = HI;
    lo_d    = LO;
    phi_d   = phi_q;
    plo_d   = plo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          case (MDUOp)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              phi_d   = res_hi;
              plo_d   = res_lo;
              cnt_d   = MDUOp[1] ? DIV_LOAD : MULT_LOAD;
              busy_d  = 1'b1;
              state_d = RUN;
            end
            OP_MTHI: hi_d = A;
            OP_MTLO: lo_d = A;
            default: ;
          endcase
        end
      end
      RUN: begin
        if (cnt_q == '0) begin
          hi_d    = phi_q;
          lo_d    = plo_q;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; reset discards any in-flight result.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
      HI      <= '0;
      LO      <= '0;
      phi_q   <= '0;
      plo_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= busy_d;
      HI      <= hi_d;
      LO      <= lo_d;
      phi_q   <= phi_d;
      plo_q   <= plo_d;
    end
  end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multi-cycle multiply/divide unit for the EX stage of the pipelined MIPS CPU.
- Sits beside the combinational ALU and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Asserts busy for a parametrised latency so the hazard unit can stall MFHI/MFLO and further MDU instructions.

Parameters:
- WIDTH, 32: operand and HI/LO width in bits; legal range 8 to 64.
- MULT_CYCLES, 5: busy cycles for MULT/MULTU; must be at least 1.
- DIV_CYCLES, 10: busy cycles for DIV/DIVU; must be at least 1.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  request qualifier; op, A and B are sampled on the clk edge where start is 1.
- MDUOp  input  3  operation select: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6-7 no-op.
- A  input  WIDTH  rs operand: multiplicand, dividend, or MTHI/MTLO data.
- B  input  WIDTH  rt operand: multiplier or divisor.
- busy  output  1  high while a MULT/DIV is in flight.
- HI  output  WIDTH  architectural HI register.
- LO  output  WIDTH  architectural LO register.

Behaviour:
- Reset:
  - Asynchronous and active-high.
  - Forces busy=0, HI=0, LO=0, state=IDLE and cycle counter=0 immediately, regardless of clk.
  - Reset mid-operation discards the pending result; HI/LO are not updated afterwards.
- State machine IDLE -> RUN -> IDLE:
  - IDLE: busy=0. On an edge with start=1 and MDUOp in 0-3, latch the computed {hi,lo} result into pending registers, load counter with N-1, and enter RUN. N is MULT_CYCLES for ops 0-1 and DIV_CYCLES for ops 2-3.
  - RUN: busy=1. Counter decrements each edge. On the edge where counter==0, commit pending to HI/LO, drop busy and return to IDLE. The commit and the busy fall happen on the same edge.
- Latency: start sampled at edge k gives busy=1 during cycles k..k+N-1, and HI/LO hold the new value after edge k+N.
- MTHI/MTLO:
  - Accepted only in IDLE.
  - Write A into HI (MTHI) or LO (MTLO) at the sampling edge.
  - Visible the next cycle; busy never asserted.
- Ignored requests, each with no effect on state:
  - start while busy=1. The hazard unit guarantees this does not occur; the block must still ignore it and must not restart the counter.
  - MDUOp 6-7.
  - start=0.
- HI/LO are otherwise held; they never change while busy=1.
- Arithmetic, all results WIDTH bits:
  - MULT: signed 2*WIDTH-bit product; HI=upper half, LO=lower half.
  - MULTU: same as MULT, unsigned.
  - DIV: LO=quotient truncated toward zero, HI=remainder carrying the dividend's sign.
  - DIVU: unsigned quotient and remainder.
  - Signed overflow (A = most-negative value, B = -1): LO=A, HI=0.
  - Divide by zero, both signed and unsigned: LO=all ones, HI=A; latency unchanged.
- Operands are sampled only at the start edge. Later changes to A/B during RUN have no effect.
- Implementation is free to compute iteratively inside RUN, provided the commit edge and results match the above exactly.
- No X on any output after reset.

Test Plan:
- Reset then idle: assert reset async mid-cycle -> busy=0, HI=0, LO=0 immediately; hold 20 cycles with start=0 -> all unchanged.
- MULT signed, WIDTH=32: A=0xFFFFFFFE (-2), B=3, start for 1 cycle:
  - busy=1 for exactly 5 cycles.
  - After the 5th edge, HI=0xFFFFFFFF, LO=0xFFFFFFFA.
  - Same operands with MULTU -> HI=0x00000002, LO=0xFFFFFFFA.
- DIV/DIVU:
  - DIV A=-7 (0xFFFFFFF9), B=2 -> busy 10 cycles, LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - DIVU A=7, B=2 -> LO=3, HI=1.
  - DIV A=0x80000000, B=0xFFFFFFFF -> LO=0x80000000, HI=0.
- Divide by zero: DIVU A=0x1234, B=0 -> after 10 cycles LO=0xFFFFFFFF, HI=0x1234.
- Interference during RUN: start MULT 3*4, then on the next cycle pulse start with MTLO A=0x55 and change A/B -> request ignored, busy length still 5, final HI=0, LO=12.
  - MTHI 0xABCD while idle -> HI=0xABCD next cycle, busy stays 0.
- Reset mid-operation: start DIV 100/7, assert reset at cycle 4 of RUN -> busy=0 and HI=LO=0 at once. After release, no late commit occurs within 15 cycles.
